// File: rtl/m3_pkg.sv
// Shared definitions for the M3 motion sequencer: command opcodes, FSM state
// encodings and the small helpers used by the sequencer and its level ramps.
package m3_pkg;

  // Command opcodes carried on cmdOpI; 6 and 7 are illegal.
  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_START     = 3'd1;
  localparam logic [2:0] CMD_STOP      = 3'd2;
  localparam logic [2:0] CMD_SET_SPEED = 3'd3;
  localparam logic [2:0] CMD_SET_POWER = 3'd4;
  localparam logic [2:0] CMD_REVERSE   = 3'd5;

  // Sequencer states; the encoding is visible on stateO.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STARTUP = 3'd1,
    ST_RUN     = 3'd2,
    ST_RAMPDN  = 3'd3,
    ST_BRAKE   = 3'd4,
    ST_FAULT   = 3'd5
  } m3State_t;

  // One tick is the rising edge of the calc block's 100 Hz output; prev is
  // the registered copy of the same signal.
  function automatic logic risingEdge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  // Clamp a requested level to its ceiling.
  function automatic logic [7:0] satLevel(input logic [7:0] val, input logic [7:0] maxVal);
    return (val > maxVal) ? maxVal : val;
  endfunction

  function automatic logic isLegalOp(input logic [2:0] op);
    return op <= CMD_REVERSE;
  endfunction

endpackage

// File: rtl/m3_level_ramp.sv
// One ramped level (speed or power): holds a target and a level, moves the
// level one step toward the target per tick and reports the direction as
// INC/DEC flags that persist until the next tick.
module m3_level_ramp
  import m3_pkg::*;
#(
  parameter logic [7:0] MAX = 8'd64
) (
  input  logic       clkI,
  input  logic       rstI,
  input  logic       clrI,      // zero level, target and requests
  input  logic       quietI,    // zero requests only, keep level/target
  input  logic       enI,       // ramping allowed in the current state
  input  logic       tickI,
  input  logic       tgtLoadI,
  input  logic [7:0] tgtValI,
  output logic [7:0] levelO,
  output logic [7:0] tgtO,
  output logic       incO,
  output logic       decO
);

  logic [7:0] level;
  logic [7:0] tgt;
  logic       inc;
  logic       dec;

  // Target load, one-step ramp and request flags, all on a tick boundary.
  always_ff @(posedge clkI) begin
    if (rstI || clrI) begin
      level <= '0;
      tgt   <= '0;
      inc   <= 1'b0;
      dec   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates mean a target loaded in this cycle is not
      // seen by a tick in the same cycle; the comparison uses the old target.
      if (tgtLoadI) tgt <= satLevel(tgtValI, MAX);
      if (quietI) begin
        inc <= 1'b0;
        dec <= 1'b0;
      end else if (tickI) begin
        if (enI && (level < tgt)) begin
          inc   <= 1'b1;
          dec   <= 1'b0;
          level <= level + 8'd1;
        end else if (enI && (level > tgt)) begin
          inc   <= 1'b0;
          dec   <= 1'b1;
          level <= level - 8'd1;
        end else begin
          inc <= 1'b0;
          dec <= 1'b0;
        end
      end
    end
  end

  assign levelO = level;
  assign tgtO   = tgt;
  assign incO   = inc;
  assign decO   = dec;

endmodule

// File: rtl/m3_motion_sequencer.sv
// Command-driven sequencer in front of the M3 power/speed calc block. Takes
// one command at a time, paces speed/power ramps on the 100 Hz tick and
// enforces ramp-down, brake dwell and restart around stops and reversals.
module m3_motion_sequencer
  import m3_pkg::*;
#(
  parameter logic [7:0] SPD_MAX     = 8'd64,
  parameter logic [7:0] PWR_MAX     = 8'd32,
  parameter logic [7:0] START_TICKS = 8'd4,
  parameter logic [7:0] BRAKE_TICKS = 8'd8
) (
  input  logic       clkI,
  input  logic       rstI,
  input  logic       tick100hzI,
  input  logic       cmdValidI,
  output logic       cmdReadyO,
  input  logic [2:0] cmdOpI,
  input  logic [7:0] cmdArgI,
  input  logic       estopI,
  output logic       m3startO,
  output logic       m3forceStopO,
  output logic       m3invRotateO,
  output logic       m3speedINCo,
  output logic       m3speedDECo,
  output logic       m3powerINCo,
  output logic       m3powerDECo,
  output logic [7:0] spdLevelO,
  output logic [2:0] stateO,
  output logic       errO
);

  m3State_t   state;
  m3State_t   nextState;
  logic       tickPrev;
  logic       tickPulse;
  logic [7:0] tickCnt;
  logic       revPending;
  logic [7:0] savedSpdTgt;
  logic       invRotate;
  logic       err;

  logic       accept;
  logic       faultClr;
  logic       spdLoad;
  logic [7:0] spdLoadVal;
  logic       pwrLoad;
  logic [7:0] pwrLoadVal;
  logic       saveRev;
  logic       revVal;
  logic       toggleInv;
  logic       clrErr;
  logic       setErr;

  logic [7:0] spdLevel;
  logic [7:0] spdTgt;
  logic [7:0] pwrLevel;
  logic [7:0] pwrTgt;
  logic       unusedPwr;

  assign tickPulse = risingEdge(tick100hzI, tickPrev);
  assign cmdReadyO = ((state == ST_IDLE) || (state == ST_RUN)) && !estopI;
  assign accept    = cmdValidI && cmdReadyO;
  assign faultClr  = estopI || (state == ST_FAULT);
  assign setErr    = estopI || (accept && !isLegalOp(cmdOpI));

  // Power level and target only steer the calc block via INC/DEC.
  assign unusedPwr = ^{pwrLevel, pwrTgt};

  // Registered copy of the tick input for edge detection.
  always_ff @(posedge clkI) begin
    if (rstI) tickPrev <= 1'b0;
    else      tickPrev <= tick100hzI;
  end

  // Next-state and per-cycle strobes; estop overrides everything.
  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    nextState  = state;
    spdLoad    = 1'b0;
    spdLoadVal = '0;
    pwrLoad    = 1'b0;
    pwrLoadVal = '0;
    saveRev    = 1'b0;
    revVal     = 1'b0;
    toggleInv  = 1'b0;
    clrErr     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmdOpI)
            CMD_START: begin
              nextState = ST_STARTUP;
              clrErr    = 1'b1;
            end
            CMD_SET_SPEED: begin
              spdLoad    = 1'b1;
              spdLoadVal = cmdArgI;
            end
            CMD_SET_POWER: begin
              pwrLoad    = 1'b1;
              pwrLoadVal = cmdArgI;
            end
            default: ;
          endcase
        end
      end
      ST_STARTUP: begin
        if (tickPulse && (tickCnt == START_TICKS - 8'd1)) nextState = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          case (cmdOpI)
            CMD_SET_SPEED: begin
              spdLoad    = 1'b1;
              spdLoadVal = cmdArgI;
            end
            CMD_SET_POWER: begin
              pwrLoad    = 1'b1;
              pwrLoadVal = cmdArgI;
            end
            CMD_STOP, CMD_REVERSE: begin
              // Park the speed target at zero and remember where to return.
              nextState  = ST_RAMPDN;
              spdLoad    = 1'b1;
              spdLoadVal = 8'd0;
              saveRev    = 1'b1;
              revVal     = (cmdOpI == CMD_REVERSE);
            end
            default: ;
          endcase
        end
      end
      ST_RAMPDN: begin
        if (spdLevel == 8'd0) nextState = ST_BRAKE;
      end
      ST_BRAKE: begin
        if (tickPulse && (tickCnt == BRAKE_TICKS - 8'd1)) begin
          if (revPending) begin
            nextState  = ST_STARTUP;
            spdLoad    = 1'b1;
            spdLoadVal = savedSpdTgt;
            toggleInv  = 1'b1;
          end else begin
            nextState = ST_IDLE;
          end
        end
      end
      ST_FAULT: begin
        if (!estopI) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase

    if (estopI) begin
      nextState = ST_FAULT;
      spdLoad   = 1'b0;
      pwrLoad   = 1'b0;
      saveRev   = 1'b0;
      toggleInv = 1'b0;
      clrErr    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clkI) begin
    if (rstI) state <= ST_IDLE;
    else      state <= nextState;
  end

  // Tick counter for STARTUP/BRAKE dwell, restarted on every state change.
  always_ff @(posedge clkI) begin
    if (rstI || (nextState != state)) tickCnt <= '0;
    else if (tickPulse)               tickCnt <= tickCnt + 8'd1;
  end

  // Reversal bookkeeping: pending flag, saved target and rotation direction.
  always_ff @(posedge clkI) begin
    if (rstI) begin
      revPending  <= 1'b0;
      savedSpdTgt <= '0;
      invRotate   <= 1'b0;
    end else begin
      if (saveRev) begin
        revPending  <= revVal;
        savedSpdTgt <= spdTgt;
      end
      if (toggleInv) invRotate <= ~invRotate;
    end
  end

  // Sticky error flag; set wins over the clear from START.
  always_ff @(posedge clkI) begin
    if (rstI)        err <= 1'b0;
    else if (setErr) err <= 1'b1;
    else if (clrErr) err <= 1'b0;
  end

  m3_level_ramp #(.MAX(SPD_MAX)) uSpdRamp (
    .clkI     (clkI),
    .rstI     (rstI),
    .clrI     (faultClr),
    .quietI   (1'b0),
    .enI      ((state == ST_RUN) || (state == ST_RAMPDN)),
    .tickI    (tickPulse),
    .tgtLoadI (spdLoad),
    .tgtValI  (spdLoadVal),
    .levelO   (spdLevel),
    .tgtO     (spdTgt),
    .incO     (m3speedINCo),
    .decO     (m3speedDECo)
  );

  // Power keeps its level through faults; only its requests are silenced.
  m3_level_ramp #(.MAX(PWR_MAX)) uPwrRamp (
    .clkI     (clkI),
    .rstI     (rstI),
    .clrI     (1'b0),
    .quietI   (faultClr),
    .enI      (state == ST_RUN),
    .tickI    (tickPulse),
    .tgtLoadI (pwrLoad),
    .tgtValI  (pwrLoadVal),
    .levelO   (pwrLevel),
    .tgtO     (pwrTgt),
    .incO     (m3powerINCo),
    .decO     (m3powerDECo)
  );

  assign m3startO     = (state == ST_STARTUP) || (state == ST_RUN) ||
                        (state == ST_RAMPDN)  || (state == ST_BRAKE);
  assign m3forceStopO = (state == ST_BRAKE) || (state == ST_FAULT);
  assign m3invRotateO = invRotate;
  assign spdLevelO    = spdLevel;
  assign stateO       = state;
  assign errO         = err;

endmodule

// File: tb/tb_m3_motion_sequencer.sv
// Directed bench for m3_motion_sequencer: a table of command/tick steps with
// hand-computed expected outputs, then hand sequences for estop and reset.
module tb_m3_motion_sequencer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       cmdValid;
  logic       cmdReady;
  logic [2:0] cmdOp;
  logic [7:0] cmdArg;
  logic       estop;
  logic       m3start, m3forceStop, m3invRotate;
  logic       spdInc, spdDec, pwrInc, pwrDec;
  logic [7:0] spdLevel;
  logic [2:0] stateOut;
  logic       err;

  int checks   = 0;
  int failures = 0;

  m3_motion_sequencer dut (
    .clkI         (clk),
    .rstI         (rst),
    .tick100hzI   (tick),
    .cmdValidI    (cmdValid),
    .cmdReadyO    (cmdReady),
    .cmdOpI       (cmdOp),
    .cmdArgI      (cmdArg),
    .estopI       (estop),
    .m3startO     (m3start),
    .m3forceStopO (m3forceStop),
    .m3invRotateO (m3invRotate),
    .m3speedINCo  (spdInc),
    .m3speedDECo  (spdDec),
    .m3powerINCo  (pwrInc),
    .m3powerDECo  (pwrDec),
    .spdLevelO    (spdLevel),
    .stateO       (stateOut),
    .errO         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       doCmd;
    logic [2:0] op;
    logic [7:0] arg;
    int         ticks;
    logic [2:0] st;
    logic [7:0] spd;
    logic       sInc, sDec, pInc, pDec;
    logic       start, fstop, inv, err, rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One tick: a single high cycle followed by two low cycles.
  task automatic doTick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
  endtask

  task automatic sendCmd(input logic [2:0] op, input logic [7:0] arg);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdArg   = arg;
    step();
    cmdValid = 1'b0;
    cmdOp    = 3'd0;
    cmdArg   = 8'd0;
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    check({tag, ".state"}, 32'(stateOut),    32'(v.st));
    check({tag, ".spd"},   32'(spdLevel),    32'(v.spd));
    check({tag, ".sInc"},  32'(spdInc),      32'(v.sInc));
    check({tag, ".sDec"},  32'(spdDec),      32'(v.sDec));
    check({tag, ".pInc"},  32'(pwrInc),      32'(v.pInc));
    check({tag, ".pDec"},  32'(pwrDec),      32'(v.pDec));
    check({tag, ".start"}, 32'(m3start),     32'(v.start));
    check({tag, ".fstop"}, 32'(m3forceStop), 32'(v.fstop));
    check({tag, ".inv"},   32'(m3invRotate), 32'(v.inv));
    check({tag, ".err"},   32'(err),         32'(v.err));
    check({tag, ".rdy"},   32'(cmdReady),    32'(v.rdy));
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; cmdValid = 1'b0; cmdOp = 3'd0; cmdArg = 8'd0; estop = 1'b0;

    //                  cmd  op    arg     tk  st    spd    sI    sD    pI    pD    strt  fst   inv   err   rdy
    vecs.push_back(vec_t'{1'b1, 3'd7, 8'd0,   0, 3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}); // illegal op
    vecs.push_back(vec_t'{1'b1, 3'd3, 8'd3,   0, 3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}); // SET_SPEED 3
    vecs.push_back(vec_t'{1'b1, 3'd1, 8'd0,   0, 3'd1, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}); // START
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   3, 3'd1, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd2, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}); // RUN
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd2, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   2, 3'd2, 8'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd2, 8'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'd5, 8'd0,   0, 3'd3, 8'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}); // REVERSE
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd3, 8'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   2, 3'd4, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}); // BRAKE
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   7, 3'd4, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd1, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}); // restart
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   4, 3'd2, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   3, 3'd2, 8'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd2, 8'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'd3, 8'd200, 0, 3'd2, 8'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}); // saturating
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,  61, 3'd2, 8'd64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd2, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   2, 3'd2, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'd4, 8'd2,   0, 3'd2, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}); // SET_POWER 2
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd2, 8'd64, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd2, 8'd64, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd2, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'd4, 8'd0,   0, 3'd2, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}); // SET_POWER 0
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd2, 8'd64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd2, 8'd64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   1, 3'd2, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'd2, 8'd0,   0, 3'd3, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}); // STOP
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,  64, 3'd4, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd0, 8'd0,   8, 3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}); // back to IDLE

    // Reset state.
    repeat (3) step();
    rst = 1'b0;
    checkAll("reset", vec_t'{1'b0, 3'd0, 8'd0, 0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    // Table-driven command/tick steps.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].doCmd) sendCmd(vecs[i].op, vecs[i].arg);
      for (int t = 0; t < vecs[i].ticks; t++) doTick();
      checkAll($sformatf("v%0d", i), vecs[i]);
    end

    // Back to RUN and ramp toward 5.
    sendCmd(3'd1, 8'd0);
    check("restart.state", 32'(stateOut), 32'd1);
    for (int t = 0; t < 4; t++) doTick();
    sendCmd(3'd3, 8'd5);
    doTick();
    doTick();
    check("ramp5.spd",  32'(spdLevel), 32'd2);
    check("ramp5.sInc", 32'(spdInc),   32'd1);

    // Command and tick in the same cycle: the tick still uses the old target.
    tick = 1'b1; cmdValid = 1'b1; cmdOp = 3'd3; cmdArg = 8'd2;
    step();
    tick = 1'b0; cmdValid = 1'b0; cmdOp = 3'd0; cmdArg = 8'd0;
    check("same.spd",  32'(spdLevel), 32'd3);
    check("same.sInc", 32'(spdInc),   32'd1);
    step();
    doTick();
    check("newtgt.spd",  32'(spdLevel), 32'd2);
    check("newtgt.sDec", 32'(spdDec),   32'd1);
    check("newtgt.sInc", 32'(spdInc),   32'd0);

    // Emergency stop while running.
    estop = 1'b1;
    step();
    check("estop.state", 32'(stateOut),    32'd5);
    check("estop.fstop", 32'(m3forceStop), 32'd1);
    check("estop.start", 32'(m3start),     32'd0);
    check("estop.sInc",  32'(spdInc),      32'd0);
    check("estop.sDec",  32'(spdDec),      32'd0);
    check("estop.pInc",  32'(pwrInc),      32'd0);
    check("estop.pDec",  32'(pwrDec),      32'd0);
    check("estop.spd",   32'(spdLevel),    32'd0);
    check("estop.err",   32'(err),         32'd1);
    check("estop.rdy",   32'(cmdReady),    32'd0);
    step();
    step();
    check("estop.hold", 32'(stateOut), 32'd5);
    estop = 1'b0;
    step();
    check("release.state", 32'(stateOut),    32'd0);
    check("release.spd",   32'(spdLevel),    32'd0);
    check("release.err",   32'(err),         32'd1);
    check("release.rdy",   32'(cmdReady),    32'd1);
    check("release.fstop", 32'(m3forceStop), 32'd0);

    // START clears the sticky error.
    sendCmd(3'd1, 8'd0);
    check("clrerr.state", 32'(stateOut), 32'd1);
    check("clrerr.err",   32'(err),      32'd0);
    check("preRst.inv",   32'(m3invRotate), 32'd1);

    // Reset mid-operation returns everything, including rotation, to reset values.
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkAll("midRst", vec_t'{1'b0, 3'd0, 8'd0, 0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m3_motion_sequencer.md
Name: m3_motion_sequencer

Overview:
Command-driven sequencer in front of the M3 power/speed calculation block. Accepts one command at a time over a valid/ready handshake. Drives the calc block's start, force-stop, invert-rotation and INC/DEC level inputs, paced by the calc block's 100 Hz tick. Enforces the motor-safe ordering: ramp down before reversal or stop, brake dwell, then restart.

Parameters:
SPD_MAX, 8'd64, maximum speed level, in tick units
PWR_MAX, 8'd32, maximum power level, in tick units
START_TICKS, 8'd4, tick count that m3startO is held before ramping begins
BRAKE_TICKS, 8'd8, tick count that m3forceStopO is held after ramp-down

Ports:
clkI  in  1  system clock
rstI  in  1  reset; synchronous, active-high
tick100hzI  in  1  clk100hzO from the calc block; the rising edge is one tick
cmdValidI  in  1  command valid
cmdReadyO  out  1  command accepted when valid&&ready
cmdOpI  in  3  0=NOP 1=START 2=STOP 3=SET_SPEED 4=SET_POWER 5=REVERSE, 6/7 illegal
cmdArgI  in  8  target level for SET_SPEED/SET_POWER
estopI  in  1  emergency stop, level
m3startO  out  1  to m3startI
m3forceStopO  out  1  to m3forceStopI
m3invRotateO  out  1  to m3invRotateI
m3speedINCo  out  1  speed increase request
m3speedDECo  out  1  speed decrease request
m3powerINCo  out  1  power increase request
m3powerDECo  out  1  power decrease request
spdLevelO  out  8  current speed level
stateO  out  3  FSM state encoding
errO  out  1  sticky: illegal op or estop seen; cleared by reset or START

Behaviour:
- Reset: every output is 0. Exception: cmdReadyO=1. State=IDLE. All levels, targets, counters and tickPrev are 0.
- Tick: tickPulse = tick100hzI & ~tickPrev. tickPrev is registered.
- Handshake: cmdReadyO=1 only in IDLE and RUN. A command is accepted on the clkI edge where cmdValidI&&cmdReadyO. Its effect is visible on the next cycle.
- Command handling:
  - NOP: ignored.
  - Ops 6/7: set errO; otherwise ignored.
  - SET_SPEED / SET_POWER: set spdTgt / pwrTgt. Arguments above SPD_MAX / PWR_MAX saturate to the max.
- FSM states, stateO encoding:
  - IDLE(0): m3startO=0. START moves to STARTUP and clears errO. STOP and REVERSE are ignored. SET_* only load the target.
  - STARTUP(1): m3startO=1. Count START_TICKS tickPulses, then go to RUN.
  - RUN(2): m3startO=1.
    - Speed is evaluated on each tickPulse. If spdLevel<spdTgt: INC=1 and spdLevel+1. If spdLevel>spdTgt: DEC=1 and spdLevel-1. If equal: both 0.
    - INC/DEC are registered and hold their value until the next tickPulse.
    - Power is handled the same way with pwrLevel/pwrTgt, independently of speed.
    - STOP: save revPending=0 and go to RAMPDN.
    - REVERSE: save revPending=1 and go to RAMPDN.
  - RAMPDN(3): cmdReadyO=0. spdTgt is forced to 0. One DEC per tick until spdLevel==0, then go to BRAKE.
  - BRAKE(4): m3forceStopO=1 and m3startO=1. Hold for BRAKE_TICKS tickPulses.
    - If revPending=1: toggle m3invRotateO, restore spdTgt from saved target, go to STARTUP.
    - If revPending=0: go to IDLE. pwrLevel is kept.
  - FAULT(5): entered from any state when estopI=1. This has priority over all commands and tick actions.
    - All motion outputs are 0 and m3forceStopO=1. spdLevel=spdTgt=0. errO=1. cmdReadyO=0.
    - Exit to IDLE on the first cycle estopI=0.
- Speed and power requests are never asserted together in the same direction conflict: INC and DEC of the same quantity are mutually exclusive.
- Level arithmetic is 8-bit and saturating: no wrap below 0 or above the max.
- A command and a tickPulse in the same cycle: the command updates targets first, and the tick acts on the new target in the next tick only.
- rstI mid-operation: immediate return to reset values on the next edge, including m3invRotateO=0.

Decomposition:
- Shared package m3_pkg holds:
  - command opcode localparams (CMD_NOP..CMD_REVERSE);
  - FSM state encodings;
  - the tick edge detector convention.
- One natural sub-module, m3_level_ramp (used twice, for speed and power). It holds a level register with target, tickPulse, saturation and clear, and outputs inc/dec/level.

Test Plan:
- Reset, then START, then SET_SPEED 3 → STARTUP held 4 ticks, then exactly 3 ticks with m3speedINCo=1, then spdLevelO=3 and INC=DEC=0.
- In RUN at level 3, REVERSE → cmdReadyO=0; 3 ticks DEC; 8 ticks m3forceStopO=1; m3invRotateO 0→1; STARTUP; ramp back to 3.
- SET_SPEED 200 with SPD_MAX=64 → target saturates; spdLevelO ends at 64 and never exceeds it.
- SET_POWER 2 then SET_POWER 0 while RUN → 2 ticks m3powerINCo, then 2 ticks m3powerDECo. Speed outputs are unaffected.
- estopI pulse during ramp → next cycle FAULT (stateO=5), m3forceStopO=1, all INC/DEC=0, errO=1. After release: IDLE, spdLevelO=0.
- cmdOpI=7 in IDLE → errO=1 and state unchanged. A following START clears errO.
